// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, hazard inputs and EX-side outputs of the ID/EX register
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic [REGW-1:0] id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_alu_src;
  logic [3:0]      id_alu_ctrl;
  logic            flush;
  logic [REGW-1:0] mem_rd;
  logic            mem_reg_write;
  logic [REGW-1:0] wb_rd;
  logic            wb_reg_write;
  logic            stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [REGW-1:0] ex_rs1;
  logic [REGW-1:0] ex_rs2;
  logic [REGW-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_alu_src;
  logic [3:0]      ex_alu_ctrl;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic [15:0]     bubble_cnt;
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_alu_ctrl,
           flush, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    input  stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_ctrl,
           forward_a, forward_b, bubble_cnt
  );
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_alu_ctrl,
           flush, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    output stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_ctrl,
           forward_a, forward_b, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, forwarding selects and bubble counter
module id_ex_stage (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);
  logic counted;
  logic bubble;
  // load-use hazard, EX operand forward selects (MEM over WB, never x0) and bubble decision
  always_comb begin
    bus.stall = !bus.flush && bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != '0) && bus.id_valid &&
                ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    bus.forward_a = (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs1)) ? 2'b10 :
                    (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.ex_rs1)) ? 2'b01 : 2'b00;
    bus.forward_b = (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs2)) ? 2'b10 :
                    (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.ex_rs2)) ? 2'b01 : 2'b00;
    counted = bus.flush || bus.stall;
    bubble = counted || !bus.id_valid;
  end
  // pipeline register: bubbles clear valid/write controls and rd, data fields hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_pc        <= '0;
      bus.ex_rs1_data  <= '0;
      bus.ex_rs2_data  <= '0;
      bus.ex_imm       <= '0;
      bus.ex_rs1       <= '0;
      bus.ex_rs2       <= '0;
      bus.ex_rd        <= '0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_alu_src   <= 1'b0;
      bus.ex_alu_ctrl  <= '0;
    end else if (bubble) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_rd        <= '0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
    end else begin
      bus.ex_valid     <= 1'b1;
      bus.ex_pc        <= bus.id_pc;
      bus.ex_rs1_data  <= bus.id_rs1_data;
      bus.ex_rs2_data  <= bus.id_rs2_data;
      bus.ex_imm       <= bus.id_imm;
      bus.ex_rs1       <= bus.id_rs1;
      bus.ex_rs2       <= bus.id_rs2;
      bus.ex_rd        <= bus.id_rd;
      bus.ex_reg_write <= bus.id_reg_write;
      bus.ex_mem_read  <= bus.id_mem_read;
      bus.ex_mem_write <= bus.id_mem_write;
      bus.ex_alu_src   <= bus.id_alu_src;
      bus.ex_alu_ctrl  <= bus.id_alu_ctrl;
    end
  end
  // saturating count of bubbles caused by stall or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.bubble_cnt <= '0;
    else if (counted && bus.bubble_cnt != '1) bus.bubble_cnt <= bus.bubble_cnt + 16'd1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  id_ex_stage_if #(.XLEN(32), .REGW(5)) bus ();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, as;
    logic [3:0]  ctrl;
  } ex_t;
  ex_t m;
  int cnt;
  int checks = 0;
  int errors = 0;
  int prev;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic exp_stall();
    return !bus.flush && m.valid && m.mr && m.rd != 0 && bus.id_valid &&
           (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
  endfunction
  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == r) return 2'b10;
    if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == r) return 2'b01;
    return 2'b00;
  endfunction
  task automatic check_comb();
    chk("stall", 32'(bus.stall), 32'(exp_stall()));
    chk("forward_a", 32'(bus.forward_a), 32'(exp_fwd(m.rs1)));
    chk("forward_b", 32'(bus.forward_b), 32'(exp_fwd(m.rs2)));
  endtask
  task automatic check_regs();
    chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
    chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
    chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
    chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
    chk("ex_pc", bus.ex_pc, m.pc);
    chk("ex_rs1_data", bus.ex_rs1_data, m.d1);
    chk("ex_rs2_data", bus.ex_rs2_data, m.d2);
    chk("ex_imm", bus.ex_imm, m.imm);
    chk("ex_rs1", 32'(bus.ex_rs1), 32'(m.rs1));
    chk("ex_rs2", 32'(bus.ex_rs2), 32'(m.rs2));
    chk("ex_alu_src", 32'(bus.ex_alu_src), 32'(m.as));
    chk("ex_alu_ctrl", 32'(bus.ex_alu_ctrl), 32'(m.ctrl));
    chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(cnt));
  endtask
  task automatic tick();
    logic s;
    s = exp_stall();
    @(posedge clk);
    if (bus.flush || s || !bus.id_valid) begin
      if (bus.flush || s) cnt = (cnt < 65535) ? cnt + 1 : cnt;
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.rd = 0;
    end else begin
      m = '{1'b1, bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm, bus.id_rs1, bus.id_rs2,
            bus.id_rd, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_alu_src, bus.id_alu_ctrl};
    end
    #1 check_regs();
  endtask
  task automatic set_id(input logic v, input logic [31:0] pc, d1, d2, imm, input logic [4:0] r1, r2, rd,
                        input logic rw, mr, mw, as, input logic [3:0] c);
    bus.id_valid = v; bus.id_pc = pc; bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
    bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_rd = rd; bus.id_reg_write = rw; bus.id_mem_read = mr;
    bus.id_mem_write = mw; bus.id_alu_src = as; bus.id_alu_ctrl = c;
  endtask
  task automatic rand_inputs();
    set_id($urandom_range(9) < 8, $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(7)),
           5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom), $urandom_range(9) < 3, 1'($urandom),
           1'($urandom), 4'($urandom));
    bus.flush = $urandom_range(9) == 0;
    bus.mem_rd = 5'($urandom_range(7)); bus.mem_reg_write = 1'($urandom);
    bus.wb_rd = 5'($urandom_range(7)); bus.wb_reg_write = 1'($urandom);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m = '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    cnt = 0;
    check_regs();
    check_comb();
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_fwd_a", 32'(bus.forward_a), 32'd0);
  endtask
  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 0; bus.mem_rd = 0; bus.mem_reg_write = 0; bus.wb_rd = 0; bus.wb_reg_write = 0;
    #2 do_reset();
    @(negedge clk) rst_n = 1'b1;
    set_id(1, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 4'd0);
    #1 check_comb();
    tick();
    chk("cap_pc", bus.ex_pc, 32'h100);
    chk("cap_rs1_data", bus.ex_rs1_data, 32'hDEADBEEF);
    chk("cap_rd", 32'(bus.ex_rd), 32'd5);
    chk("cap_valid", 32'(bus.ex_valid), 32'd1);
    set_id(1, 32'h104, 32'h11, 32'h22, 32'h33, 5'd3, 5'd4, 5'd6, 1, 0, 0, 1, 4'd2);
    #1 check_comb();
    tick();
    bus.id_valid = 0;
    bus.mem_rd = 3; bus.mem_reg_write = 1; bus.wb_rd = 3; bus.wb_reg_write = 1;
    #1 chk("fwd_a_mem_prio", 32'(bus.forward_a), 32'd2);
    check_comb();
    bus.wb_rd = 4;
    #1 chk("fwd_a_mem", 32'(bus.forward_a), 32'd2);
    chk("fwd_b_wb", 32'(bus.forward_b), 32'd1);
    bus.mem_rd = 0; bus.wb_rd = 0;
    #1 chk("fwd_a_x0", 32'(bus.forward_a), 32'd0);
    chk("fwd_b_x0", 32'(bus.forward_b), 32'd0);
    bus.mem_reg_write = 0; bus.wb_reg_write = 0;
    tick();
    chk("idle_no_count", 32'(bus.bubble_cnt), 32'd0);
    set_id(1, 32'h108, 32'h0, 32'h0, 32'h4, 5'd1, 5'd2, 5'd7, 1, 1, 0, 1, 4'd0);
    #1 check_comb();
    tick();
    set_id(1, 32'h10C, 32'h5, 32'h6, 32'h0, 5'd9, 5'd7, 5'd8, 1, 0, 0, 0, 4'd1);
    #1 chk("load_use_stall", 32'(bus.stall), 32'd1);
    check_comb();
    tick();
    chk("lu_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu_ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("lu_bubble_cnt", 32'(bus.bubble_cnt), 32'd1);
    chk("lu_stall_clear", 32'(bus.stall), 32'd0);
    tick();
    chk("lu_dep_in_ex", bus.ex_pc, 32'h10C);
    set_id(1, 32'h110, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 4'd0);
    #1 check_comb();
    tick();
    set_id(1, 32'h114, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 1, 0, 0, 0, 4'd0);
    #1 chk("load_x0_no_stall", 32'(bus.stall), 32'd0);
    check_comb();
    tick();
    set_id(1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd7, 1, 1, 0, 1, 4'd0);
    #1 check_comb();
    tick();
    set_id(1, 32'h11C, 32'h0, 32'h0, 32'h0, 5'd7, 5'd2, 5'd4, 1, 0, 0, 0, 4'd0);
    bus.flush = 1;
    #1 chk("flush_kills_stall", 32'(bus.stall), 32'd0);
    check_comb();
    prev = cnt;
    tick();
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_count_once", 32'(bus.bubble_cnt), 32'(prev + 1));
    bus.flush = 0;
    #1 check_comb();
    tick();
    chk("pre_reset_valid", 32'(bus.ex_valid), 32'd1);
    #2 do_reset();
    chk("async_reset_valid", 32'(bus.ex_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      #1 check_comb();
      if (i == 1500) begin
        #1 do_reset();
        @(negedge clk) rst_n = 1'b1;
        #1 check_comb();
      end
      tick();
    end
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1;
    repeat (65540) tick();
    chk("sat_cnt", 32'(bus.bubble_cnt), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(bus.bubble_cnt), 32'hFFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
